// File: rtl/junction_cycle_scheduler.sv
// Global cycle scheduler: locks NJ junction index counters, each with its own CPC[j], to one
// CPC_MAX-long global cycle. Define CYCLE_COUNT_EN to build the saturating completed-cycle counter.
module junction_cycle_scheduler #(
   parameter int unsigned NJ             = 2,
   parameter logic [31:0] CPC [0:NJ-1]   = '{32'd6, 32'd4},
   parameter int unsigned CPC_MAX        = 6,
   parameter int unsigned CW             = $clog2(CPC_MAX)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             stall_i,
   output logic [NJ*CW-1:0] cycle_index_o,
   output logic [NJ-1:0]    j_active_o,
   output logic             cycle_clk_o,
   output logic             busy_o,
   output logic [31:0]      num_cycles_o
);

   function automatic logic [31:0] max_cpc();
      logic [31:0] m;
      m = '0;
      for (int j = 0; j < int'(NJ); j++) begin
         if (CPC[j] > m) m = CPC[j];
      end
      return m;
   endfunction

   // Every junction window must be 2^x+2 clocks long and the global cycle must match the longest.
   for (genvar j = 0; j < int'(NJ); j++) begin : g_cpc_chk
      if (CPC[j] < 32'd3 || ((CPC[j] - 32'd2) & (CPC[j] - 32'd3)) != 32'd0) begin : g_bad_cpc
         $fatal(1, "junction_cycle_scheduler: CPC[%0d]=%0d is not 2^x+2 >= 3", j, CPC[j]);
      end
   end
   if (32'(CPC_MAX) != max_cpc()) begin : g_bad_max
      $fatal(1, "junction_cycle_scheduler: CPC_MAX=%0d differs from max(CPC)", CPC_MAX);
   end

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] gidx_q, gidx_d;
   logic [31:0]   gidx_ext;
   logic          wrap;

   assign busy_o   = (state_q == StRun);
   assign wrap     = (gidx_q == CW'(CPC_MAX - 1));
   assign gidx_ext = 32'(gidx_q);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      unique case (state_q)
         StIdle: begin
            if (run_i) begin
               state_d = StRun;
               gidx_d  = '0;
            end
         end
         StRun: begin
            // Stall freezes everything, including a wrap that would otherwise happen now.
            if (!stall_i) begin
               if (wrap) begin
                  gidx_d = '0;
                  if (!run_i) state_d = StIdle;
               end else begin
                  gidx_d = gidx_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            gidx_d  = '0;
         end
      endcase
   end

   always_comb begin
      cycle_index_o = '0;
      j_active_o    = '0;
      cycle_clk_o   = busy_o & ~stall_i & wrap;
      if (busy_o) begin
         for (int j = 0; j < int'(NJ); j++) begin
            // Shorter junctions park on their last index until the global cycle wraps.
            if (gidx_ext < CPC[j]) begin
               cycle_index_o[j*CW +: CW] = gidx_q;
               j_active_o[j]             = 1'b1;
            end else begin
               cycle_index_o[j*CW +: CW] = CW'(CPC[j] - 32'd1);
            end
         end
      end
   end

`ifdef CYCLE_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   assign cnt_d = (cycle_clk_o && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign num_cycles_o = cnt_q;
`else
   assign num_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_junction_cycle_scheduler.sv
// Directed bench for junction_cycle_scheduler (NJ=2, CPC={6,4}, CPC_MAX=6) with a scoreboard queue.
module tb_junction_cycle_scheduler;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        stall;
   logic [5:0]  cycle_index;
   logic [1:0]  j_active;
   logic        cycle_clk;
   logic        busy;
   logic [31:0] num_cycles;

   junction_cycle_scheduler #(
      .NJ      (2),
      .CPC     ('{32'd6, 32'd4}),
      .CPC_MAX (6),
      .CW      (3)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .run_i         (run),
      .stall_i       (stall),
      .cycle_index_o (cycle_index),
      .j_active_o    (j_active),
      .cycle_clk_o   (cycle_clk),
      .busy_o        (busy),
      .num_cycles_o  (num_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  idx;
      logic [1:0]  ja;
      logic        cc;
      logic        bsy;
      logic [31:0] nc;
   } exp_t;

   exp_t sb[$];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state after the most recent posedge
   logic        m_run;
   int unsigned m_g;
   logic [31:0] m_cnt;

   // Observations from the last step, for literal checks
   logic [5:0]  obs_idx;
   logic [1:0]  obs_ja;
   logic        obs_cc;
   logic        obs_bsy;
   logic [31:0] obs_nc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic exp_t model_out(input logic s);
      exp_t e;
      int unsigned i0, i1;
      e = '0;
      if (m_run) begin
         i0    = (m_g < 6) ? m_g : 5;
         i1    = (m_g < 4) ? m_g : 3;
         e.idx = {i1[2:0], i0[2:0]};
         e.ja  = {(m_g < 4), (m_g < 6)};
         e.cc  = ~s && (m_g == 5);
         e.bsy = 1'b1;
      end
`ifdef CYCLE_COUNT_EN
      e.nc = m_cnt;
`else
      e.nc = 32'd0;
`endif
      return e;
   endfunction

   task automatic step(input logic r, input logic s, input logic rn, input string tag);
      exp_t e;
      @(negedge clk);
      run   = r;
      stall = s;
      rst_n = rn;
      sb.push_back(model_out(s));
      #1;
      obs_idx = cycle_index;
      obs_ja  = j_active;
      obs_cc  = cycle_clk;
      obs_bsy = busy;
      obs_nc  = num_cycles;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_idx"}, 64'(obs_idx), 64'(e.idx));
         chk({tag, "_jact"}, 64'(obs_ja), 64'(e.ja));
         chk({tag, "_cclk"}, 64'(obs_cc), 64'(e.cc));
         chk({tag, "_busy"}, 64'(obs_bsy), 64'(e.bsy));
         chk({tag, "_ncyc"}, 64'(obs_nc), 64'(e.nc));
      end
      @(posedge clk);
      if (!rn) begin
         m_run = 1'b0;
         m_g   = 0;
         m_cnt = 32'd0;
      end else if (!m_run) begin
         if (r) begin
            m_run = 1'b1;
            m_g   = 0;
         end
      end else if (!s) begin
         if (m_g == 5) begin
            m_g = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (!r) m_run = 1'b0;
         end else begin
            m_g = m_g + 1;
         end
      end
   endtask

   logic [2:0] lit_i1 [6];
   logic [1:0] lit_ja [6];
   logic [31:0] exp_ncyc;

   initial begin
      lit_i1 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
      lit_ja = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
      m_run  = 1'b0;
      m_g    = 0;
      m_cnt  = 32'd0;
      rst_n  = 1'b0;
      run    = 1'b0;
      stall  = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, then idle with run low
      step(1'b0, 1'b0, 1'b1, "reset");
      chk("reset_busy_lit", 64'(obs_bsy), 64'd0);

      // 1: start and one clean cycle
      step(1'b1, 1'b0, 1'b1, "start");
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b1, "t1");
         chk("t1_idx0_lit", 64'(obs_idx[2:0]), 64'(i));
         chk("t1_idx1_lit", 64'(obs_idx[5:3]), 64'(lit_i1[i]));
         chk("t1_jact_lit", 64'(obs_ja), 64'(lit_ja[i]));
         chk("t1_cclk_lit", 64'(obs_cc), 64'(i == 5));
      end

      // 2: stall three clocks at gidx=2
      step(1'b1, 1'b0, 1'b1, "t2_pre");
      step(1'b1, 1'b0, 1'b1, "t2_pre");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, "t2_stall");
         chk("t2_hold_lit", 64'(obs_idx[2:0]), 64'd2);
      end
      step(1'b1, 1'b0, 1'b1, "t2_rel");
      step(1'b1, 1'b0, 1'b1, "t2_post");
      chk("t2_gidx3_lit", 64'(obs_idx[2:0]), 64'd3);
      step(1'b1, 1'b0, 1'b1, "t2_post");
      step(1'b1, 1'b0, 1'b1, "t2_post");

      // 3: stall at the wrap clock
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, "t3_pre");
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, "t3_stall");
         chk("t3_nostrobe_lit", 64'(obs_cc), 64'd0);
      end
      step(1'b1, 1'b0, 1'b1, "t3_rel");
      chk("t3_strobe_lit", 64'(obs_cc), 64'd1);
      step(1'b1, 1'b0, 1'b1, "t3_wrap");
      chk("t3_gidx0_lit", 64'(obs_idx[2:0]), 64'd0);

      // 4: run dropped at gidx=1 drains the cycle
      step(1'b0, 1'b0, 1'b1, "t4_drop");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, "t4_drain");
      chk("t4_last_strobe_lit", 64'(obs_cc), 64'd1);
      step(1'b0, 1'b0, 1'b1, "t4_idle");
      chk("t4_idle_busy_lit", 64'(obs_bsy), 64'd0);
      chk("t4_idle_jact_lit", 64'(obs_ja), 64'd0);

      // 5: reset mid-cycle with run held high
      step(1'b1, 1'b0, 1'b1, "t5_start");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, "t5_run");
      step(1'b1, 1'b0, 1'b0, "t5_rst");
      chk("t5_pre_rst_gidx_lit", 64'(obs_idx[2:0]), 64'd3);
      step(1'b1, 1'b0, 1'b1, "t5_after");
      chk("t5_after_busy_lit", 64'(obs_bsy), 64'd0);
      chk("t5_after_idx_lit", 64'(obs_idx), 64'd0);

      // 6: ten full cycles from a freshly reset counter
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b1, "t6");
      step(1'b0, 1'b0, 1'b1, "t6_done");
`ifdef CYCLE_COUNT_EN
      exp_ncyc = 32'd10;
`else
      exp_ncyc = 32'd0;
`endif
      chk("t6_ncyc_lit", 64'(obs_nc), 64'(exp_ncyc));
      chk("t6_busy_lit", 64'(obs_bsy), 64'd1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, "t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
